// File: rtl/fifo_broadcast_buffered.sv
// One-to-many stream broadcaster with a private FIFO per consumer.
// A slow consumer only stalls the input once its own buffer is full.
module fifo_broadcast_buffered #(
    parameter int DATA_WIDTH = 32,
    parameter int SIGNALS    = 4,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH-1:0]              data_in,
    input  logic                               data_in_valid,
    output logic                               data_in_ready,
    input  logic [SIGNALS-1:0]                 channel_enable,
    output logic [DATA_WIDTH*SIGNALS-1:0]      data_out,
    output logic [SIGNALS-1:0]                 data_out_valid,
    input  logic [SIGNALS-1:0]                 data_out_ready,
    output logic [SIGNALS*(DEPTH_LOG2+1)-1:0]  level,
    output logic                               all_empty
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam int LW    = DEPTH_LOG2 + 1;

    logic [SIGNALS-1:0] full;
    logic               accept;

    // Only registered counts gate the input; a same-cycle pop frees nothing.
    assign data_in_ready = (|channel_enable) && !(|(channel_enable & full));
    assign accept        = data_in_valid && data_in_ready;
    assign all_empty     = ~(|data_out_valid);

    for (genvar c = 0; c < SIGNALS; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem [DEPTH];
        logic [DEPTH_LOG2-1:0] wr_ptr;
        logic [DEPTH_LOG2-1:0] rd_ptr;
        logic [LW-1:0]         count;
        logic                  push;
        logic                  pop;

        assign push = accept && channel_enable[c];
        assign pop  = data_out_valid[c] && data_out_ready[c];

        assign full[c]           = (count == LW'(DEPTH));
        assign data_out_valid[c] = (count != '0);
        assign level[c*LW +: LW] = count;

        assign data_out[c*DATA_WIDTH +: DATA_WIDTH] = mem[rd_ptr];

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end

        // Storage is intentionally left unreset.
        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: doc/fifo_broadcast_buffered.md
# fifo_broadcast_buffered

Parametrised one-to-many stream broadcaster. Each of `SIGNALS` consumers gets its own `2**DEPTH_LOG2`-entry FIFO, so a slow consumer does not stall the others until its buffer fills. A runtime channel mask selects which consumers receive each new word. The block replaces the single-register splitter wherever backprop/forward datapaths fan one valid/ready stream out to several layers or units.

## Interface

- `DATA_WIDTH`, 32, width of one data word
- `SIGNALS`, 4, number of output channels
- `DEPTH_LOG2`, 2, log2 of per-channel FIFO depth (DEPTH = 2**DEPTH_LOG2, DEPTH_LOG2 ≥ 1)

- `clk` input 1: clock, all state on rising edge
- `rst` input 1: reset, synchronous, active-high
- `data_in` input DATA_WIDTH: input word
- `data_in_valid` input 1: input word present
- `data_in_ready` output 1: block accepts word this cycle
- `channel_enable` input SIGNALS: bit c set → channel c receives words accepted this cycle
- `data_out` output DATA_WIDTH*SIGNALS: channel c head word at bits [c*DATA_WIDTH +: DATA_WIDTH]
- `data_out_valid` output SIGNALS: channel c head word present
- `data_out_ready` input SIGNALS: channel c consumer takes head word
- `level` output SIGNALS*(DEPTH_LOG2+1): channel c occupancy at [c*(DEPTH_LOG2+1) +: DEPTH_LOG2+1]
- `all_empty` output 1: every channel level is 0

## Operation

- Per channel: storage array of DEPTH words, write pointer and read pointer (DEPTH_LOG2 bits, natural wrap), count (DEPTH_LOG2+1 bits, 0..DEPTH).
- `data_in_ready` = (`channel_enable` != 0) AND, for every c with `channel_enable[c]`=1, count[c] < DEPTH. It is combinational from `channel_enable` and registered counts only. Same-cycle pops do not free space.
- Accept = `data_in_valid` && `data_in_ready`. On accept, `data_in` is written at wr_ptr[c] of every enabled channel, and those wr_ptr/count values advance. Disabled channels are untouched.
- Pop on channel c = `data_out_valid[c]` && `data_out_ready[c]`. It advances rd_ptr[c] and decrements count[c].
- Push and pop on the same channel in the same cycle leave count unchanged and move both pointers.
- `data_out_valid[c]` = count[c] != 0. `data_out` slice c = storage[c][rd_ptr[c]].
- `channel_enable` affects only new writes. Words already buffered in a channel that becomes disabled still drain normally, in order.
- `channel_enable` = 0: `data_in_ready`=0, and input stalls regardless of `data_in_valid`.
- Per-channel ordering is strict FIFO. Channels are independent: no cross-channel ordering or skew constraint.
- Reset: all pointers and counts are 0, `data_out_valid`=0, `level`=0, `all_empty`=1. `data_in_ready` = |`channel_enable`. Storage is not reset. `data_out` is don't-care while the matching valid is low.
- `rst` mid-operation discards all buffered words in the next cycle, with no partial pops.

## Timing

- Latency: a word accepted in cycle N is visible on `data_out`/`data_out_valid` of each enabled channel in cycle N+1.
- Throughput: 1 word/cycle in, and 1 word/cycle per channel out, while no enabled channel is full.
- Full channel: `data_in_ready` falls in the cycle after the accept that makes count = DEPTH. It rises in the cycle after the first pop from that channel, or immediately in the same cycle when that channel is removed from `channel_enable`.
- `level` and `all_empty` are registered-count derived and update the cycle after a push or pop.
- `data_out_valid` must not depend combinationally on `data_out_ready`.

## Test plan

- Reset: assert `rst` 2 cycles with `channel_enable`=4'b1111. Require `data_out_valid`=0, all levels 0, `all_empty`=1, `data_in_ready`=1.
- Broadcast: push 0x000000A5 in cycle N with all `data_out_ready`=1. In N+1, all four channels are valid with 0xA5. In N+2, valid=0 and `all_empty`=1.
- Lagging consumer: ch2 ready=0, others 1; push 0x1..0x5 back-to-back. Words 0x1–0x4 are accepted, then level2=4 and `data_in_ready`=0, so 0x5 is held. Raise ch2 ready for one cycle M: ch2 pops 0x1, and 0x5 is accepted in M+1. ch2 then drains 0x2,0x3,0x4,0x5.
- Mask: with ch2 full (0x1..0x4), set `channel_enable`=4'b1011. `data_in_ready`=1 the same cycle. Push 0x10,0x11: they go to ch0/1/3 only. Level2 stays 4, and ch2 drains 0x1..0x4 with no 0x10/0x11.
- Stall: `channel_enable`=0 with `data_in_valid`=1 for 5 cycles. Require `data_in_ready`=0 and no level change.
- Wrap/simultaneous: ch0 only, ready toggling pseudo-randomly; stream 0x100..0x10F (16 words, 4 wraps). Require ch0 outputs in exact order. Holding ch0 at level 4 while popping and offering a push in the same cycle leaves the push unaccepted (ready=0), and level becomes 3.
